// File: rtl/key_boot_pkg.sv
// Shared types and constants for the boot-time key loader.
package key_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StOtpReq,
        StWbWr,
        StDone,
        StError
    } boot_state_e;

    localparam logic [31:0]  KEY_BASE_DFLT  = 32'h0008_0000;
    localparam int unsigned  NUM_WORDS_DFLT = 24;
    localparam int unsigned  OTP_AW         = 5;

    localparam logic [2:0]   CTI_CLASSIC    = 3'b000;
    localparam logic [1:0]   BTE_LINEAR     = 2'b00;

    localparam logic [7:0] KEY_OFFSETS [NUM_WORDS_DFLT] = '{
        8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
        8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C,
        8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, 8'h5C
    };

    function automatic logic [31:0] key_offset(input logic [OTP_AW-1:0] word);
        return {25'd0, word, 2'b00};
    endfunction

endpackage

// File: rtl/key_boot_loader.sv
// Boot-time Wishbone master: copies OTP key words into the key register window and
// holds the CPU in reset until every word has landed; any failure keeps the hold.
module key_boot_loader
    import key_boot_pkg::*;
#(
    parameter int unsigned dw          = 32,
    parameter int unsigned aw          = 32,
    parameter logic [31:0] KEY_BASE    = KEY_BASE_DFLT,
    parameter int unsigned NUM_WORDS   = NUM_WORDS_DFLT,
    parameter int unsigned OTP_TIMEOUT = 255,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    output logic              otp_req_o,
    output logic [OTP_AW-1:0] otp_addr_o,
    input  logic              otp_valid_i,
    input  logic [31:0]       otp_data_i,
    input  logic              otp_err_i,
    output logic [aw-1:0]     wbm_adr_o,
    output logic [dw-1:0]     wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic [2:0]        wbm_cti_o,
    output logic [1:0]        wbm_bte_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              cpu_hold_o
);

    localparam logic [OTP_AW-1:0] LAST_IDX     = OTP_AW'(NUM_WORDS - 1);
    localparam logic [7:0]        TIMEOUT_LAST = 8'(OTP_TIMEOUT - 1);

    boot_state_e       state;
    logic [OTP_AW-1:0] idx;
    logic [7:0]        wait_cnt;
    logic [31:0]       key_word;
    logic              otp_fail;

    // A valid response in the final allowed cycle still counts; an error always wins.
    assign otp_fail  = otp_err_i || (!otp_valid_i && (wait_cnt == TIMEOUT_LAST));
    assign wbm_dat_o = dw'(key_word);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= StIdle;
            idx        <= '0;
            wait_cnt   <= '0;
            key_word   <= '0;
            otp_req_o  <= 1'b0;
            otp_addr_o <= '0;
            wbm_adr_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cti_o  <= '0;
            wbm_bte_o  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            cpu_hold_o <= 1'b1;
        end else begin
            case (state)
                StIdle, StDone, StError: begin
                    if (start_i || (AUTO_START && (state == StIdle))) begin
                        state      <= StOtpReq;
                        idx        <= '0;
                        wait_cnt   <= '0;
                        otp_req_o  <= 1'b1;
                        otp_addr_o <= '0;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        error_o    <= 1'b0;
                        cpu_hold_o <= 1'b1;
                    end
                end
                StOtpReq: begin
                    if (otp_fail) begin
                        state     <= StError;
                        otp_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                        error_o   <= 1'b1;
                    end else if (otp_valid_i) begin
                        state     <= StWbWr;
                        key_word  <= otp_data_i;
                        otp_req_o <= 1'b0;
                        wbm_adr_o <= aw'(KEY_BASE + key_offset(idx));
                        wbm_sel_o <= 4'hF;
                        wbm_we_o  <= 1'b1;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_cti_o <= CTI_CLASSIC;
                        wbm_bte_o <= BTE_LINEAR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StWbWr: begin
                    if (wbm_err_i || wbm_ack_i) begin
                        wbm_sel_o <= '0;
                        wbm_we_o  <= 1'b0;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                    end
                    if (wbm_err_i) begin
                        state   <= StError;
                        busy_o  <= 1'b0;
                        error_o <= 1'b1;
                    end else if (wbm_ack_i) begin
                        if (idx == LAST_IDX) begin
                            state      <= StDone;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            cpu_hold_o <= 1'b0;
                        end else begin
                            state      <= StOtpReq;
                            idx        <= idx + 1'b1;
                            otp_addr_o <= idx + 1'b1;
                            otp_req_o  <= 1'b1;
                            wait_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    // Unreachable encodings fail secure.
                    state     <= StError;
                    otp_req_o <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    busy_o    <= 1'b0;
                    error_o   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_boot_loader.sv
// Self-checking bench for key_boot_loader: OTP and Wishbone slave responders with
// per-word latencies, a write monitor, and a word-level model of the expected load.
module tb_key_boot_loader;

    localparam logic [31:0] KEY_BASE    = 32'h0008_0000;
    localparam int          NUM_WORDS   = 24;
    localparam int          OTP_TIMEOUT = 255;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
        int          held;
        bit          stable;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        otp_req;
    logic [4:0]  otp_addr;
    logic        otp_valid = 1'b0;
    logic [31:0] otp_data = '0;
    logic        otp_err = 1'b0;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack = 1'b0;
    logic        berr = 1'b0;
    logic        busy, done, failed, cpu_hold;

    int checks = 0;
    int errors = 0;

    logic [31:0] otp_mem [32];
    int          otp_lat [32];
    int          ack_lat [32];
    int          otp_err_word = -1;
    int          wb_err_word = -1;
    int          otp_stall_word = -1;

    wr_t writes[$];
    wr_t cur;
    bit  in_cyc = 1'b0;
    bit  prev_ack = 1'b0;
    int  bus_errs = 0;
    int  b2b = 0;
    bit  cyc_seen = 1'b0;
    int  ocnt = 0;
    int  acnt = 0;

    key_boot_loader #(
        .dw(32), .aw(32), .KEY_BASE(KEY_BASE), .NUM_WORDS(NUM_WORDS),
        .OTP_TIMEOUT(OTP_TIMEOUT), .AUTO_START(1'b1)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .otp_req_o(otp_req), .otp_addr_o(otp_addr), .otp_valid_i(otp_valid),
        .otp_data_i(otp_data), .otp_err_i(otp_err),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
        .wbm_ack_i(ack), .wbm_err_i(berr),
        .busy_o(busy), .done_o(done), .error_o(failed), .cpu_hold_o(cpu_hold)
    );

    always #5 clk = ~clk;

    // OTP responder: answers otp_lat[word] cycles after the request is seen.
    always @(posedge clk) begin
        int w;
        #1;
        w = int'(otp_addr);
        if (otp_req && !rst && (w != otp_stall_word) && (ocnt >= otp_lat[w])) begin
            otp_valid = 1'b1;
            otp_data  = otp_mem[w];
            otp_err   = (w == otp_err_word);
        end else begin
            otp_valid = 1'b0;
            otp_err   = 1'b0;
            otp_data  = $urandom();
            ocnt      = (otp_req && !rst) ? ocnt + 1 : 0;
        end
    end

    // Slave responder: on the error word both ack and err are raised together.
    always @(posedge clk) begin
        int w;
        #1;
        w = int'(adr[6:2]);
        if (cyc && stb && !rst && (acnt >= ack_lat[w])) begin
            ack  = 1'b1;
            berr = (w == wb_err_word);
        end else begin
            ack  = 1'b0;
            berr = 1'b0;
            acnt = (cyc && stb && !rst) ? acnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            in_cyc   = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (cyc) cyc_seen = 1'b1;
            if (cyc && stb) begin
                if (prev_ack) b2b++;
                if (!in_cyc) begin
                    cur    = '{adr, dat, sel, we, cti, bte, 1, 1'b1};
                    in_cyc = 1'b1;
                end else begin
                    cur.held++;
                    if ({adr, dat, sel, we, cti, bte} !==
                        {cur.adr, cur.dat, cur.sel, cur.we, cur.cti, cur.bte})
                        cur.stable = 1'b0;
                end
                prev_ack = ack || berr;
                if (berr) begin
                    bus_errs++;
                    in_cyc = 1'b0;
                end else if (ack) begin
                    writes.push_back(cur);
                    in_cyc = 1'b0;
                end
            end else begin
                in_cyc   = 1'b0;
                prev_ack = 1'b0;
            end
        end
    end

    // Model: expected write for word n, and the cycle count of a load of n words.
    function automatic logic [73:0] exp_word(input int n);
        return {KEY_BASE + 32'(4 * n), otp_mem[n], 4'hF, 1'b1, 3'b000, 2'b00};
    endfunction

    function automatic logic [73:0] got_word(input wr_t w);
        return {w.adr, w.dat, w.sel, w.we, w.cti, w.bte};
    endfunction

    function automatic int exp_cycles(input int nwords);
        int c = 1;
        for (int n = 0; n < nwords; n++) c += 2 + otp_lat[n] + ack_lat[n];
        return c;
    endfunction

    task automatic setup(input bit rand_lat, input bit pattern);
        for (int n = 0; n < 32; n++) begin
            otp_mem[n] = pattern ? (32'hA5A5_0000 + 32'(n)) : $urandom();
            otp_lat[n] = rand_lat ? int'($urandom_range(0, 3)) : 1;
            ack_lat[n] = rand_lat ? int'($urandom_range(0, 3)) : 1;
        end
        otp_err_word = -1;
        wb_err_word = -1;
        otp_stall_word = -1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        writes.delete();
        bus_errs = 0;
        b2b = 0;
        cyc_seen = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wait_end(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < limit) begin
            @(posedge clk);
            #2;
            cycles++;
            if (done || failed) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        setup(1'b0, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({otp_req, otp_addr, adr, dat, sel, we, cyc, stb, cti, bte, busy, done, failed} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%0d adr=%h dat=%h sel=%h cyc=%b busy=%b done=%b err=%b, all required 0",
                     otp_req, otp_addr, adr, dat, sel, cyc, busy, done, failed);
        end
        checks++;
        if (cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: cpu_hold=%b required 1", cpu_hold);
        end
        rst = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if ({otp_req, otp_addr, busy, cyc} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL auto_start: req=%b addr=%0d busy=%b cyc=%b required 1 0 1 0",
                     otp_req, otp_addr, busy, cyc);
        end
    endtask

    task automatic test_auto_load();
        int cyc_cnt;
        bit ok;
        setup(1'b0, 1'b1);
        apply_reset();
        wait_end(2000, cyc_cnt, ok);
        checks++;
        if (!ok || cyc_cnt !== 97) begin
            errors++;
            $display("FAIL auto_cycles: got %0d (ended=%b) required 97", cyc_cnt, ok);
        end
        checks++;
        if ({done, failed, cpu_hold, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL auto_status: done/err/hold/busy=%b required 1000", {done, failed, cpu_hold, busy});
        end
        checks++;
        if (writes.size() !== NUM_WORDS || b2b !== 0) begin
            errors++;
            $display("FAIL auto_count: writes=%0d b2b=%0d required %0d 0", writes.size(), b2b, NUM_WORDS);
        end
        for (int n = 0; n < writes.size() && n < NUM_WORDS; n++) begin
            checks++;
            if (got_word(writes[n]) !== exp_word(n) || !writes[n].stable || writes[n].held !== 2) begin
                errors++;
                $display("FAIL auto_write%0d: got %h held=%0d required %h held=2",
                         n, got_word(writes[n]), writes[n].held, exp_word(n));
            end
        end
    endtask

    task automatic test_slow_slave();
        int cyc_cnt;
        bit ok;
        setup(1'b0, 1'b0);
        ack_lat[5] = 3;
        apply_reset();
        wait_end(2000, cyc_cnt, ok);
        checks++;
        if (!ok || cyc_cnt !== exp_cycles(NUM_WORDS) || done !== 1'b1) begin
            errors++;
            $display("FAIL slow_cycles: got %0d done=%b required %0d done=1", cyc_cnt, done, exp_cycles(NUM_WORDS));
        end
        checks++;
        if (writes.size() < 6 || writes[5].adr !== 32'h0008_0014 || writes[5].held !== 4 ||
            !writes[5].stable || writes[5].dat !== otp_mem[5]) begin
            errors++;
            $display("FAIL slow_hold: writes=%0d adr=%h held=%0d stable=%b required 00080014 4 1",
                     writes.size(), writes.size() > 5 ? writes[5].adr : 32'hx,
                     writes.size() > 5 ? writes[5].held : -1, writes.size() > 5 ? writes[5].stable : 1'b0);
        end
    endtask

    task automatic test_random_load();
        int cyc_cnt;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            setup(1'b1, 1'b0);
            apply_reset();
            fork
                wait_end(2000, cyc_cnt, ok);
                begin
                    repeat (20 + r * 7) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            join
            checks++;
            if (!ok || cyc_cnt !== exp_cycles(NUM_WORDS) || {done, cpu_hold} !== 2'b10) begin
                errors++;
                $display("FAIL rand%0d_cycles: got %0d done=%b hold=%b required %0d 1 0",
                         r, cyc_cnt, done, cpu_hold, exp_cycles(NUM_WORDS));
            end
            checks++;
            if (writes.size() !== NUM_WORDS) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d required %0d", r, writes.size(), NUM_WORDS);
            end
            for (int n = 0; n < writes.size() && n < NUM_WORDS; n++) begin
                checks++;
                if (got_word(writes[n]) !== exp_word(n) || !writes[n].stable ||
                    writes[n].held !== ack_lat[n] + 1) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: got %h held=%0d required %h held=%0d",
                             r, n, got_word(writes[n]), writes[n].held, exp_word(n), ack_lat[n] + 1);
                end
            end
        end
        // Reload from DONE: the hold comes back with the start edge.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({cpu_hold, done, busy, otp_req} !== 4'b1011) begin
            errors++;
            $display("FAIL restart_from_done: hold/done/busy/req=%b required 1011", {cpu_hold, done, busy, otp_req});
        end
    endtask

    task automatic test_otp_error();
        int cyc_cnt;
        bit ok;
        setup(1'b1, 1'b0);
        otp_err_word = 10;
        apply_reset();
        wait_end(2000, cyc_cnt, ok);
        checks++;
        if (!ok || cyc_cnt !== exp_cycles(10) + otp_lat[10] + 1) begin
            errors++;
            $display("FAIL otp_err_cycles: got %0d required %0d", cyc_cnt, exp_cycles(10) + otp_lat[10] + 1);
        end
        checks++;
        if ({failed, cpu_hold, done, busy, cyc, otp_req} !== 6'b110000 || writes.size() !== 10) begin
            errors++;
            $display("FAIL otp_err_state: err/hold/done/busy/cyc/req=%b writes=%0d required 110000 10",
                     {failed, cpu_hold, done, busy, cyc, otp_req}, writes.size());
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({failed, cpu_hold, cyc} !== 3'b110) begin
            errors++;
            $display("FAIL otp_err_sticky: err/hold/cyc=%b required 110", {failed, cpu_hold, cyc});
        end
    endtask

    task automatic test_timeout();
        int cyc_cnt;
        bit ok;
        setup(1'b0, 1'b0);
        otp_stall_word = 0;
        apply_reset();
        wait_end(1000, cyc_cnt, ok);
        checks++;
        if (!ok || cyc_cnt !== 1 + OTP_TIMEOUT || failed !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d err=%b required %0d err=1", cyc_cnt, failed, 1 + OTP_TIMEOUT);
        end
        checks++;
        if (cyc_seen || {cpu_hold, done, otp_req} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_state: cyc_seen=%b hold/done/req=%b required 0 100",
                     cyc_seen, {cpu_hold, done, otp_req});
        end
    endtask

    task automatic test_bus_error_retry();
        int cyc_cnt;
        bit ok;
        setup(1'b1, 1'b0);
        wb_err_word = 3;
        apply_reset();
        wait_end(2000, cyc_cnt, ok);
        checks++;
        if (!ok || cyc_cnt !== exp_cycles(4) || writes.size() !== 3 || bus_errs !== 1 ||
            {failed, cpu_hold, cyc} !== 3'b110) begin
            errors++;
            $display("FAIL bus_err: cycles=%0d writes=%0d berrs=%0d err/hold/cyc=%b required %0d 3 1 110",
                     cyc_cnt, writes.size(), bus_errs, {failed, cpu_hold, cyc}, exp_cycles(4));
        end
        wb_err_word = -1;
        writes.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_end(2000, cyc_cnt, ok);
        checks++;
        if (!ok || cyc_cnt + 1 !== exp_cycles(NUM_WORDS) || {done, failed, cpu_hold} !== 3'b100) begin
            errors++;
            $display("FAIL retry_status: cycles=%0d done/err/hold=%b required %0d 100",
                     cyc_cnt + 1, {done, failed, cpu_hold}, exp_cycles(NUM_WORDS));
        end
        checks++;
        if (writes.size() !== NUM_WORDS || got_word(writes[0]) !== exp_word(0) ||
            got_word(writes[NUM_WORDS-1]) !== exp_word(NUM_WORDS - 1)) begin
            errors++;
            $display("FAIL retry_writes: count=%0d required %0d from word 0", writes.size(), NUM_WORDS);
        end
    endtask

    task automatic test_mid_load_reset();
        int cyc_cnt;
        bit ok;
        bit hit = 1'b0;
        setup(1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            hit = cyc && (adr == KEY_BASE + 32'd28);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midreset_reach: word 7 write seen=%b required 1", hit);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cyc, stb, busy, cpu_hold, otp_req} !== 5'b00010) begin
            errors++;
            $display("FAIL midreset_async: cyc/stb/busy/hold/req=%b required 00010",
                     {cyc, stb, busy, cpu_hold, otp_req});
        end
        @(negedge clk);
        writes.delete();
        rst = 1'b0;
        wait_end(2000, cyc_cnt, ok);
        checks++;
        if (!ok || cyc_cnt !== exp_cycles(NUM_WORDS) || writes.size() !== NUM_WORDS ||
            writes[0].adr !== KEY_BASE || done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart: cycles=%0d writes=%0d first=%h done=%b required %0d %0d %h 1",
                     cyc_cnt, writes.size(), writes.size() > 0 ? writes[0].adr : 32'hx, done,
                     exp_cycles(NUM_WORDS), NUM_WORDS, KEY_BASE);
        end
    endtask

    initial begin
        test_reset();
        test_auto_load();
        test_slow_slave();
        test_random_load();
        test_otp_error();
        test_timeout();
        test_bus_error_retry();
        test_mid_load_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
